// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: register file read with write-through bypass, RAW hazard interlock.
// Latency 1 cycle; stall holds upstream while a source matches the EX or Q writer tag, flush wins over stall.
module operand_fetch #(
   parameter logic [15:0] NOP  = 16'h0000,
   parameter int          NREG = 8
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic [15:0] ir_in,
   input  logic [15:0] pc_in,
   input  logic        valid_in,
   input  logic        flush,
   input  logic        wb_en,
   input  logic [2:0]  wb_addr,
   input  logic [15:0] wb_data,
   output logic        stall,
   output logic [15:0] ir,
   output logic [15:0] pc,
   output logic [15:0] sr1,
   output logic [15:0] sr2,
   output logic [2:0]  dst,
   output logic        wr,
   output logic        valid_out
);

   typedef struct packed {
      logic       vld;
      logic [2:0] dst;
   } tag_t;

   logic [15:0] rf [NREG];
   logic [1:0]  op;
   logic [2:0]  fd, fs, ft;
   logic [4:0]  func;
   logic        rd_s, rd_t, is_wr;
   logic        hit_s, hit_t, issue;
   logic [15:0] opa, opb;
   tag_t        ex_tag, q_tag;

   assign op   = ir_in[15:14];
   assign fd   = ir_in[13:11];
   assign fs   = ir_in[10:8];
   assign ft   = ir_in[7:5];
   assign func = ir_in[4:0];

   always_comb begin
      rd_s  = 1'b0;
      rd_t  = 1'b0;
      is_wr = 1'b0;
      case (op)
         2'b11: begin
            is_wr = 1'b1;
            rd_s  = 1'b1;
         end
         2'b00: begin
            if (func == 5'b00010 || func == 5'b00100 || func == 5'b00101) begin
               is_wr = 1'b1;
               rd_s  = 1'b1;
               rd_t  = 1'b1;
            end
         end
         2'b01: begin
            if (fs == 3'b000) is_wr = 1'b1;
         end
         default: begin
            if (fd == 3'b001 || fd == 3'b010) rd_s = 1'b1;
         end
      endcase
   end

   // Only instructions that will actually write a register are worth tracking.
   assign ex_tag = '{vld: valid_out & wr, dst: dst};

   function automatic logic tag_hit(input tag_t tg, input logic [2:0] a);
      return tg.vld && (tg.dst == a);
   endfunction

   assign hit_s = rd_s && (tag_hit(ex_tag, fs) || tag_hit(q_tag, fs));
   assign hit_t = rd_t && (tag_hit(ex_tag, ft) || tag_hit(q_tag, ft));
   assign stall = valid_in && !flush && (hit_s || hit_t);
   assign issue = valid_in && !flush && !stall;

   assign opa = (wb_en && wb_addr == fs) ? wb_data : rf[fs];
   assign opb = (wb_en && wb_addr == ft) ? wb_data : rf[ft];

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wb_en) begin
         rf[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         q_tag     <= '0;
         ir        <= NOP;
         pc        <= '0;
         sr1       <= '0;
         sr2       <= '0;
         dst       <= '0;
         wr        <= 1'b0;
         valid_out <= 1'b0;
      end else begin
         q_tag <= ex_tag;
         if (issue) begin
            ir        <= ir_in;
            pc        <= pc_in;
            sr1       <= opa;
            sr2       <= opb;
            dst       <= fd;
            wr        <= is_wr;
            valid_out <= 1'b1;
         end else begin
            // Bubble: pc, operands and dst keep their last values.
            ir        <= NOP;
            wr        <= 1'b0;
            valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed vector bench for operand_fetch: per-cycle stall and registered-output checks.
module tb_operand_fetch;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic [15:0] ir_in, pc_in, wb_data;
   logic        valid_in, flush, wb_en;
   logic [2:0]  wb_addr;
   logic        stall;
   logic [15:0] ir, pc, sr1, sr2;
   logic [2:0]  dst;
   logic        wr, valid_out;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        vin;
      logic [15:0] ir;
      logic [15:0] pc;
      logic        fl;
      logic        wen;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic        xstall;
      logic [68:0] xout;
   } vec_t;

   vec_t vt [15];

   operand_fetch #(.NOP(16'h0000), .NREG(8)) dut (
      .CLK(CLK), .RSTN(RSTN), .ir_in(ir_in), .pc_in(pc_in), .valid_in(valid_in),
      .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .stall(stall), .ir(ir), .pc(pc), .sr1(sr1), .sr2(sr2), .dst(dst),
      .wr(wr), .valid_out(valid_out)
   );

   always #5 CLK = ~CLK;

   function automatic vec_t mk(input logic vin, input logic [15:0] i, input logic [15:0] p,
                               input logic fl, input logic wen, input logic [2:0] wa,
                               input logic [15:0] wd, input logic xs,
                               input logic [15:0] xir, input logic [15:0] xpc,
                               input logic [15:0] xs1, input logic [15:0] xs2,
                               input logic [2:0] xd, input logic xwr, input logic xvo);
      vec_t v;
      v.vin = vin; v.ir = i; v.pc = p; v.fl = fl; v.wen = wen; v.wa = wa; v.wd = wd;
      v.xstall = xs;
      v.xout = {xir, xpc, xs1, xs2, xd, xwr, xvo};
      return v;
   endfunction

   function automatic logic [68:0] outs();
      return {ir, pc, sr1, sr2, dst, wr, valid_out};
   endfunction

   task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic vin, input logic [15:0] i, input logic [15:0] p,
                        input logic fl, input logic wen, input logic [2:0] wa,
                        input logic [15:0] wd);
      valid_in = vin; ir_in = i; pc_in = p; flush = fl;
      wb_en = wen; wb_addr = wa; wb_data = wd;
   endtask

   initial begin
      // {vin, ir, pc, flush, wb_en, wb_addr, wb_data, stall | ir, pc, sr1, sr2, dst, wr, valid_out}
      vt[0]  = mk(1'b1, 16'h4805, 16'h0010, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                  16'h4805, 16'h0010, 16'h0000, 16'h0000, 3'd1, 1'b1, 1'b1);
      vt[1]  = mk(1'b1, 16'hD101, 16'h0011, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1,
                  16'h0000, 16'h0010, 16'h0000, 16'h0000, 3'd1, 1'b0, 1'b0);
      vt[2]  = mk(1'b1, 16'hD101, 16'h0011, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1,
                  16'h0000, 16'h0010, 16'h0000, 16'h0000, 3'd1, 1'b0, 1'b0);
      vt[3]  = mk(1'b1, 16'hD101, 16'h0011, 1'b0, 1'b1, 3'd1, 16'h0005, 1'b0,
                  16'hD101, 16'h0011, 16'h0005, 16'h0000, 3'd2, 1'b1, 1'b1);
      vt[4]  = mk(1'b1, 16'h2362, 16'h0012, 1'b0, 1'b1, 3'd3, 16'h1234, 1'b0,
                  16'h2362, 16'h0012, 16'h1234, 16'h1234, 3'd4, 1'b1, 1'b1);
      vt[5]  = mk(1'b1, 16'hEC00, 16'h0013, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0,
                  16'h0000, 16'h0012, 16'h1234, 16'h1234, 3'd4, 1'b0, 1'b0);
      vt[6]  = mk(1'b1, 16'hEC00, 16'h0013, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1,
                  16'h0000, 16'h0012, 16'h1234, 16'h1234, 3'd4, 1'b0, 1'b0);
      vt[7]  = mk(1'b1, 16'hEC00, 16'h0013, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                  16'hEC00, 16'h0013, 16'h0000, 16'h0000, 3'd5, 1'b1, 1'b1);
      vt[8]  = mk(1'b1, 16'h4007, 16'h0014, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                  16'h4007, 16'h0014, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b1);
      vt[9]  = mk(1'b1, 16'h8004, 16'h0015, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                  16'h8004, 16'h0015, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1);
      vt[10] = mk(1'b1, 16'h9000, 16'h0016, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1,
                  16'h0000, 16'h0015, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
      vt[11] = mk(1'b0, 16'h9000, 16'h0016, 1'b0, 1'b1, 3'd2, 16'h00AA, 1'b0,
                  16'h0000, 16'h0015, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
      vt[12] = mk(1'b1, 16'h3264, 16'h0017, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                  16'h3264, 16'h0017, 16'h00AA, 16'h1234, 3'd6, 1'b1, 1'b1);
      vt[13] = mk(1'b1, 16'h00C0, 16'h0018, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                  16'h00C0, 16'h0018, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1);
      vt[14] = mk(1'b1, 16'h39C5, 16'h0019, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1,
                  16'h0000, 16'h0018, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);

      RSTN = 1'b1;
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000);
      #2 RSTN = 1'b0;
      #1;
      chk("reset_outs", outs(), {16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0});
      chk("reset_stall", {68'd0, stall}, 69'd0);
      @(negedge CLK);
      @(negedge CLK);
      RSTN = 1'b1;

      for (int i = 0; i < 15; i++) begin
         if (i > 0) @(negedge CLK);
         drive(vt[i].vin, vt[i].ir, vt[i].pc, vt[i].fl, vt[i].wen, vt[i].wa, vt[i].wd);
         #1;
         chk($sformatf("v%0d_stall", i), {68'd0, stall}, {68'd0, vt[i].xstall});
         @(posedge CLK);
         #1;
         chk($sformatf("v%0d_outs", i), outs(), vt[i].xout);
      end

      // Reset asserted in the middle of a two-cycle stall.
      @(negedge CLK);
      drive(1'b1, 16'h4805, 16'h0020, 1'b0, 1'b0, 3'd0, 16'h0000);
      @(negedge CLK);
      drive(1'b1, 16'hD101, 16'h0021, 1'b0, 1'b0, 3'd0, 16'h0000);
      #1;
      chk("rst_seq_stall1", {68'd0, stall}, {68'd0, 1'b1});
      @(negedge CLK);
      #1;
      chk("rst_seq_stall2", {68'd0, stall}, {68'd0, 1'b1});
      RSTN = 1'b0;
      #1;
      chk("rst_seq_outs", outs(), {16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0});
      chk("rst_seq_stall_low", {68'd0, stall}, 69'd0);
      @(negedge CLK);
      RSTN = 1'b1;
      #1;
      chk("post_rst_stall", {68'd0, stall}, 69'd0);
      @(posedge CLK);
      #1;
      chk("post_rst_issue", outs(), {16'hD101, 16'h0021, 16'h0000, 16'h0000, 3'd2, 1'b1, 1'b1});

      @(negedge CLK);
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000);
      @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
